// File: rtl/fp_pkg.sv
// Shared floating-point field widths and the packed payload type carried along the pipe.
package fp_pkg;

  localparam int unsigned DEF_EXP_W  = 8;
  localparam int unsigned DEF_MANT_W = 23;
  localparam int unsigned DEF_FP_W   = 1 + DEF_EXP_W + DEF_MANT_W;

  typedef struct packed {
    logic                  sign;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_MANT_W-1:0] mant;
  } fp_t;

endpackage

// File: rtl/fp_pipe_stage.sv
// One pipeline slot: a valid bit plus payload register with load/hold and a flush
// that clears only the valid bit.
module fp_pipe_stage
  import fp_pkg::*;
#(
  parameter int unsigned W = DEF_FP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      // Bubbles leave the previous payload in place.
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fp_struct_pipe.sv
// Elastic, bubble-collapsing register pipe for fp_t payloads with per-stage taps,
// flush and an occupancy count.
module fp_struct_pipe
  import fp_pkg::*;
#(
  parameter int unsigned STAGES = 6,
  parameter int unsigned EXP_W  = DEF_EXP_W,
  parameter int unsigned MANT_W = DEF_MANT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  fp_t                           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output fp_t                           out_data,
  output fp_t                           tap_data [0:STAGES-1],
  output logic [STAGES-1:0]             tap_valid,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int unsigned W     = 1 + EXP_W + MANT_W;
  localparam int unsigned OCC_W = $clog2(STAGES+1);

  if (W != $bits(fp_t)) begin : g_width_check
    $error("fp_struct_pipe: EXP_W/MANT_W must match the widths of fp_pkg::fp_t");
  end

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_ready;
  logic [W-1:0]      w_data [0:STAGES-1];

  // A stage is ready when it or any stage downstream of it holds a bubble, or the sink accepts.
  always_comb begin
    logic w_acc;
    w_acc   = out_ready;
    w_ready = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_acc                  = w_acc || !w_valid[STAGES-1-k];
      w_ready[STAGES-1-k]    = w_acc;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(w_valid[i]);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic         w_prev_valid;
    logic [W-1:0] w_prev_data;

    if (i == 0) begin : g_head
      assign w_prev_valid = in_valid && !flush;
      assign w_prev_data  = in_data;
    end else begin : g_body
      assign w_prev_valid = w_valid[i-1];
      assign w_prev_data  = w_data[i-1];
    end

    fp_pipe_stage #(
      .W (W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_load  (w_ready[i]),
      .i_valid (w_prev_valid),
      .i_data  (w_prev_data),
      .o_valid (w_valid[i]),
      .o_data  (w_data[i])
    );

    assign tap_data[i] = w_data[i];
  end

  assign in_ready  = w_ready[0] && !flush;
  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign tap_valid = w_valid;

endmodule

// File: tb/tb_fp_struct_pipe.sv
// Self-checking bench for fp_struct_pipe (STAGES=4): FIFO scoreboard with an item count model.
module tb_fp_struct_pipe;
  import fp_pkg::*;

  localparam int unsigned STAGES = 4;
  localparam int unsigned OCC_W  = $clog2(STAGES+1);

  logic                clk = 1'b0;
  logic                rst, flush, in_valid, in_ready, out_valid, out_ready;
  fp_t                 in_data, out_data;
  fp_t                 tap_data [0:STAGES-1];
  logic [STAGES-1:0]   tap_valid;
  logic [OCC_W-1:0]    occupancy;

  typedef struct { fp_t d; int t; } item_t;
  item_t q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic h_rdy, h_exp_rdy, h_in, h_out, h_spur;
  fp_t  h_got, h_exp;
  int   h_lat;

  always #5 clk = ~clk;

  fp_struct_pipe #(
    .STAGES (STAGES),
    .EXP_W  (8),
    .MANT_W (23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .tap_data  (tap_data),
    .tap_valid (tap_valid),
    .occupancy (occupancy)
  );

  // Samples at negedge, updates the FIFO model for the coming edge, returns #1 after posedge.
  task automatic tick();
    item_t it;
    @(negedge clk);
    h_rdy     = in_ready;
    h_exp_rdy = !flush && (out_ready || q.size() < STAGES);
    h_in      = in_valid && h_exp_rdy;
    h_out     = out_valid && out_ready;
    h_got     = out_data;
    h_exp     = '0;
    h_lat     = 0;
    h_spur    = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (h_out) begin
        if (q.size() == 0) h_spur = 1'b1;
        else begin
          it    = q.pop_front();
          h_exp = it.d;
          h_lat = cyc - it.t;
        end
      end
      if (flush) q.delete();
      else if (h_in) q.push_back('{d: in_data, t: cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(output int bad, output int pops);
    bad = 0; pops = 0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int unsigned k = 0; k < 2*STAGES + 2; k++) begin
      tick();
      if (h_out) begin
        pops++;
        if (h_spur || h_got !== h_exp) bad++;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (tap_valid !== '0) begin n_fail++; $display("FAIL reset_tap_valid: got %b expected 0", tap_valid); end
    n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    for (int unsigned i = 0; i < STAGES; i++) begin
      n_tests++;
      if (tap_data[i] !== fp_t'(32'h0)) begin n_fail++; $display("FAIL reset_tap_data[%0d]: got %h expected 0", i, tap_data[i]); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] vals [4];
    int pops = 0;
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      in_valid = (k < 8);
      if (k < 4) in_data = fp_t'(vals[k]);
      else       in_data = fp_t'($urandom);
      tick();
      if (k < 8) begin
        n_tests++; if (h_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: got %b expected 1 (k=%0d)", h_rdy, k); end
      end
      if (h_out) begin
        pops++;
        n_tests++;
        if (h_spur || h_got !== h_exp || h_lat != int'(STAGES)) begin
          n_fail++; $display("FAIL stream_out: got %h lat %0d expected %h lat %0d", h_got, h_lat, h_exp, STAGES);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++; if (pops != 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", pops); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    int bad  = 0;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = fp_t'($urandom);
      tick();
      n_tests++;
      if (h_rdy !== ((k < 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL bp_in_ready: got %b at push %0d", h_rdy, k); end
    end
    tick(); tick();
    n_tests++; if (h_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready: got %b expected 0", h_rdy); end
    n_tests++; if (occupancy !== OCC_W'(4)) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
    n_tests++; if (tap_valid !== 4'b1111) begin n_fail++; $display("FAIL bp_tap_valid: got %b expected 1111", tap_valid); end
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      if (h_in) in_valid = 1'b0;
      if (h_out) begin
        pops++;
        if (h_spur || h_got !== h_exp) begin bad++; $display("FAIL bp_drain_data: got %h expected %h", h_got, h_exp); end
      end
    end
    n_tests++; if (bad != 0 || pops != 5) begin n_fail++; $display("FAIL bp_drain: got %0d pops %0d bad expected 5 pops 0 bad", pops, bad); end
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_sparse();
    int bad, pops;
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      in_valid = (i % 3 == 0);
      in_data  = fp_t'($urandom);
      tick();
      if (i % 3 == 0) begin
        n_tests++; if (h_rdy !== 1'b1) begin n_fail++; $display("FAIL sparse_in_ready: got %b expected 1 (i=%0d)", h_rdy, i); end
      end
    end
    in_valid = 1'b0;
    n_tests++; if (tap_valid !== 4'b1111) begin n_fail++; $display("FAIL sparse_tap_valid: got %b expected 1111", tap_valid); end
    n_tests++; if (occupancy !== OCC_W'(4)) begin n_fail++; $display("FAIL sparse_occupancy: got %0d expected 4", occupancy); end
    drain(bad, pops);
    n_tests++; if (bad != 0 || pops != 4) begin n_fail++; $display("FAIL sparse_drain: got %0d pops %0d bad expected 4 pops 0 bad", pops, bad); end
  endtask

  task automatic test_back_to_back();
    int bad, pops;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = fp_t'($urandom);
      tick();
    end
    in_data = fp_t'($urandom); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (h_rdy !== 1'b1 || h_out !== 1'b1) begin n_fail++; $display("FAIL b2b_handshakes: got in %b out %b expected 1 1", h_rdy, h_out); end
    n_tests++; if (h_spur || h_got !== h_exp) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", h_got, h_exp); end
    n_tests++; if (occupancy !== OCC_W'(4)) begin n_fail++; $display("FAIL b2b_occupancy: got %0d expected 4", occupancy); end
    drain(bad, pops);
    n_tests++; if (bad != 0 || pops != 4) begin n_fail++; $display("FAIL b2b_drain: got %0d pops %0d bad expected 4 pops 0 bad", pops, bad); end
  endtask

  task automatic test_flush();
    fp_t d [3];
    int bad, pops;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      d[k] = fp_t'($urandom);
      in_valid = 1'b1; in_data = d[k];
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = fp_t'($urandom); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (h_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", h_rdy); end
    n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
    n_tests++; if (out_valid !== 1'b0 || tap_valid !== '0) begin n_fail++; $display("FAIL flush_valid: got out %b taps %b expected 0", out_valid, tap_valid); end
    n_tests++;
    if (tap_data[3] !== d[0] || tap_data[2] !== d[1] || tap_data[1] !== d[2]) begin
      n_fail++; $display("FAIL flush_payload_kept: got %h %h %h expected %h %h %h",
                         tap_data[3], tap_data[2], tap_data[1], d[0], d[1], d[2]);
    end
    drain(bad, pops);
    n_tests++; if (pops != 0) begin n_fail++; $display("FAIL flush_no_stale: got %0d pops expected 0", pops); end
  endtask

  task automatic test_reset_midstream();
    int bad, pops;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = fp_t'($urandom);
      tick();
    end
    rst = 1'b1; in_data = fp_t'($urandom);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++; if (tap_valid !== '0 || occupancy !== '0) begin n_fail++; $display("FAIL rstmid_valid: got taps %b occ %0d expected 0 0", tap_valid, occupancy); end
    for (int unsigned i = 0; i < STAGES; i++) begin
      n_tests++;
      if (tap_data[i] !== fp_t'(32'h0)) begin n_fail++; $display("FAIL rstmid_tap_data[%0d]: got %h expected 0", i, tap_data[i]); end
    end
    drain(bad, pops);
    n_tests++; if (pops != 0) begin n_fail++; $display("FAIL rstmid_no_stale: got %0d pops expected 0", pops); end
  endtask

  task automatic test_random();
    int bad, pops, exp_pops;
    for (int unsigned k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = fp_t'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
      n_tests++; if (h_rdy !== h_exp_rdy) begin n_fail++; $display("FAIL rand_in_ready: got %b expected %b (k=%0d)", h_rdy, h_exp_rdy, k); end
      if (h_out) begin
        n_tests++; if (h_spur || h_got !== h_exp) begin n_fail++; $display("FAIL rand_out_data: got %h expected %h (k=%0d)", h_got, h_exp, k); end
      end
      n_tests++;
      if (occupancy !== OCC_W'(q.size()) || $countones(tap_valid) != q.size()) begin
        n_fail++; $display("FAIL rand_occupancy: got %0d taps %b expected %0d (k=%0d)", occupancy, tap_valid, q.size(), k);
      end
    end
    exp_pops = q.size();
    drain(bad, pops);
    n_tests++; if (bad != 0 || pops != exp_pops) begin n_fail++; $display("FAIL rand_drain: got %0d pops %0d bad expected %0d pops 0 bad", pops, bad, exp_pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_sparse();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_struct_pipe.md
FP_STRUCT_PIPE -- requirements
Module: fp_struct_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 6, meaning the number of register stages (minimum 1).
REQ-002 SHALL have parameter EXP_W, default 8, meaning the exponent field width.
REQ-003 SHALL have parameter MANT_W, default 23, meaning the mantissa field width.
REQ-004 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-006 SHALL have port flush, input, 1, which invalidates all stages.
REQ-007 SHALL have port in_valid, input, 1, meaning input data is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning stage 0 accepts this cycle.
REQ-009 SHALL have port in_data, input, fp_t (sign, exp[EXP_W], mant[MANT_W]), the payload.
REQ-010 SHALL have port out_valid, output, 1, equal to the valid bit of stage STAGES-1.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream consumer accepts.
REQ-012 SHALL have port out_data, output, fp_t, equal to the stage STAGES-1 payload.
REQ-013 SHALL have port tap_data, output, fp_t array [0:STAGES-1], the payload of every stage.
REQ-014 SHALL have port tap_valid, output, STAGES, the valid bit of every stage.
REQ-015 SHALL have port occupancy, output, $clog2(STAGES+1), the count of valid stages.

Function
REQ-016 Each stage i SHALL hold one payload register and one valid bit.
REQ-017 Stage ready SHALL be ready[i] = !valid[i] || ready[i+1], with ready[STAGES] = out_ready (combinational, bubble-collapsing).
REQ-018 in_ready SHALL be ready[0] && !flush.
REQ-019 Stage i SHALL load from stage i-1 (stage 0 from in_data) when ready[i] is 1; valid[i] takes valid[i-1] (stage 0: in_valid && !flush).
REQ-020 A stage that is not ready SHALL hold its payload and valid bit.
REQ-021 Payload registers SHALL load only when the incoming valid is 1; invalid slots keep their old payload.
REQ-022 With out_ready held at 1 and no flush, latency from input handshake to out_valid SHALL be exactly STAGES cycles, with a throughput of one item per cycle.
REQ-023 A full pipe with out_ready=0 SHALL deassert in_ready and lose or duplicate no item.
REQ-024 Simultaneous output handshake and input handshake on a full pipe SHALL advance all stages in that cycle.
REQ-025 flush SHALL clear all valid bits on the next edge and leave payload registers unchanged; an input offered in the flush cycle SHALL be dropped (in_ready=0).
REQ-026 occupancy SHALL equal the popcount of the registered valid bits, ranging 0..STAGES.
REQ-027 Item order SHALL be strictly FIFO.

Reset
REQ-028 On rst, every valid bit SHALL become 0 and every payload SHALL become sign=0, exp=0, mant=0.
REQ-029 After reset: out_valid=0, tap_valid=0, occupancy=0, in_ready=1.
REQ-030 rst SHALL have priority over flush and over any handshake; items in flight when rst is asserted SHALL be discarded.

Structure
REQ-031 Package fp_pkg SHALL hold EXP_W/MANT_W defaults and the parameterised fp_t struct (a typedef built from the module parameters, or a package-level parameterised type).
REQ-032 The block SHALL use one sub-module, fp_pipe_stage, which holds a single valid/payload register with load/hold/flush logic and is instantiated STAGES times via generate.

Verification (STAGES=4, EXP_W=8, MANT_W=23)
REQ-033 Reset release, then inputs 0x3F800000..0x40800000 on consecutive cycles with out_ready=1 -> the first item appears on out_data 4 cycles after its accept, with 1 item/cycle and order preserved.
REQ-034 out_ready=0, push 5 items -> accepts 4, in_ready=0 on the 5th, occupancy=4; raise out_ready -> 4 items drain in order, then the 5th is accepted.
REQ-035 Sparse input (valid every 3rd cycle) with out_ready=0 -> bubbles collapse, tap_valid=4'b1111 after 4 accepts.
REQ-036 Full pipe, out_ready=1, in_valid=1 in the same cycle -> both handshakes occur, occupancy stays 4.
REQ-037 flush asserted with in_valid=1 and 3 items held -> next cycle occupancy=0, out_valid=0, input not accepted.
REQ-038 rst asserted mid-stream with 2 items held -> next cycle all taps read 0 with valid 0; no stale item ever emerges.
